// File: rtl/tdm_demux8_if.sv
// tdm_demux8_if: serial-link input and parallel-frame output bundle of the TDM demultiplexer
interface tdm_demux8_if #(
    parameter int CH     = 8,
    parameter int SLOT_W = 4
);
    logic              din;
    logic              fs;
    logic [CH-1:0]     dout;
    logic              dout_valid;
    logic [SLOT_W-1:0] slot;
    logic              locked;
    logic              sync_err;
    logic              par_err;

    modport master (
        output din, fs,
        input  dout, dout_valid, slot, locked, sync_err, par_err
    );

    modport slave (
        input  din, fs,
        output dout, dout_valid, slot, locked, sync_err, par_err
    );
endinterface

// File: rtl/tdm_demux8.sv
// tdm_demux8: TDM demultiplexer, serial slot i -> dout[i]; optional parity slot via DEMUX_PARITY_EN
module tdm_demux8 #(
    parameter int CH     = 8,
    parameter int SLOT_W = 4
) (
    input logic         clk,
    input logic         rst,
    tdm_demux8_if.slave bus
);
`ifdef DEMUX_PARITY_EN
    localparam int N = CH + 1;
`else
    localparam int N = CH;
`endif

    typedef enum logic {HUNT, RUN} state_t;

    state_t            state, state_n;
    logic [SLOT_W-1:0] slot, slot_n;
    logic [CH-1:0]     sh, sh_n, cap, dout, dout_n;
    logic              valid, valid_n, serr, serr_n, locked;
`ifdef DEMUX_PARITY_EN
    logic              perr, perr_n;
`endif

    // Partial frame with the current bit dropped into the slot being captured
    always_comb begin
        cap = sh;
        for (int i = 0; i < CH; i++)
            if (slot == SLOT_W'(i)) cap[i] = bus.din;
    end

    // Framing FSM: lock on fs, collect slots, publish on frame end, flag violations
    always_comb begin
        state_n = state;
        slot_n  = slot;
        sh_n    = sh;
        dout_n  = dout;
        valid_n = 1'b0;
        serr_n  = 1'b0;
`ifdef DEMUX_PARITY_EN
        perr_n  = 1'b0;
`endif
        if (state == HUNT) begin
            if (bus.fs) begin
                state_n = RUN;
                slot_n  = SLOT_W'(1);
                sh_n    = CH'(bus.din);
            end
        end else if (bus.fs) begin
            serr_n = slot != '0;
            slot_n = SLOT_W'(1);
            sh_n   = CH'(bus.din);
        end else if (slot == '0) begin
            serr_n  = 1'b1;
            state_n = HUNT;
        end else if (slot == SLOT_W'(N - 1)) begin
            slot_n = '0;
`ifdef DEMUX_PARITY_EN
            perr_n  = ^sh ^ bus.din;
            valid_n = !perr_n;
            dout_n  = perr_n ? dout : sh;
`else
            valid_n = 1'b1;
            dout_n  = cap;
`endif
        end else begin
            sh_n   = cap;
            slot_n = slot + SLOT_W'(1);
        end
    end

    // State and output registers; reset discards any partial frame
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= HUNT;
            slot   <= '0;
            sh     <= '0;
            dout   <= '0;
            valid  <= 1'b0;
            serr   <= 1'b0;
            locked <= 1'b0;
`ifdef DEMUX_PARITY_EN
            perr   <= 1'b0;
`endif
        end else begin
            state  <= state_n;
            slot   <= slot_n;
            sh     <= sh_n;
            dout   <= dout_n;
            valid  <= valid_n;
            serr   <= serr_n;
            locked <= state_n == RUN;
`ifdef DEMUX_PARITY_EN
            perr   <= perr_n;
`endif
        end
    end

    assign bus.dout       = dout;
    assign bus.dout_valid = valid;
    assign bus.slot       = slot;
    assign bus.locked     = locked;
    assign bus.sync_err   = serr;
`ifdef DEMUX_PARITY_EN
    assign bus.par_err    = perr;
`else
    assign bus.par_err    = 1'b0;
`endif
endmodule

// File: tb/tb_tdm_demux8.sv
// tb_tdm_demux8: frame table, corner sequences and random streams against a queue-based frame model
module tb_tdm_demux8;
    localparam int CH     = 8;
    localparam int SLOT_W = 4;
`ifdef DEMUX_PARITY_EN
    localparam int N   = CH + 1;
    localparam bit PAR = 1'b1;
`else
    localparam int N   = CH;
    localparam bit PAR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tdm_demux8_if #(.CH(CH), .SLOT_W(SLOT_W)) bus ();
    tdm_demux8 #(.CH(CH), .SLOT_W(SLOT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int nvec = 0;
    int nerr = 0;

    bit         m_locked = 1'b0;
    logic [7:0] m_dout   = 8'h00;
    bit         m_valid, m_serr, m_perr;
    bit         bits[$];

    typedef struct {
        logic [7:0] data;
        bit         pgood;
        logic [7:0] exp_dout;
        bit         exp_valid;
        bit         exp_perr;
    } frame_t;
    frame_t tab[5];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: bits collected since the last frame start live in a queue
    task automatic model_step(bit r, bit d, bit f);
        bit         x;
        logic [7:0] w;
        m_valid = 1'b0;
        m_serr  = 1'b0;
        m_perr  = 1'b0;
        if (r) begin
            bits.delete();
            m_locked = 1'b0;
            m_dout   = 8'h00;
        end else if (!m_locked) begin
            if (f) begin
                bits     = {d};
                m_locked = 1'b1;
            end
        end else if (f) begin
            m_serr = bits.size() != 0;
            bits   = {d};
        end else if (bits.size() == 0) begin
            m_serr   = 1'b1;
            m_locked = 1'b0;
        end else begin
            bits.push_back(d);
            if (bits.size() == N) begin
                x = 1'b0;
                foreach (bits[i]) x ^= bits[i];
                for (int i = 0; i < CH; i++) w[i] = bits[i];
                if (!PAR || !x) begin
                    m_dout  = w;
                    m_valid = 1'b1;
                end else begin
                    m_perr = 1'b1;
                end
                bits.delete();
            end
        end
    endtask

    task automatic compare_all();
        check("dout", bus.dout, m_dout);
        check("dout_valid", bus.dout_valid, m_valid);
        check("slot", bus.slot, bits.size());
        check("locked", bus.locked, m_locked);
        check("sync_err", bus.sync_err, m_serr);
        check("par_err", bus.par_err, m_perr);
    endtask

    task automatic tick(bit r, bit d, bit f);
        rst     = r;
        bus.din = d;
        bus.fs  = f;
        @(posedge clk);
        model_step(r, d, f);
        #1;
        compare_all();
    endtask

    task automatic send_frame(logic [7:0] data, bit pgood);
        for (int i = 0; i < N; i++)
            tick(1'b0, i < CH ? data[i] : (^data ^ !pgood), i == 0);
    endtask

    initial begin
        int pos;
        bit f, r;
        bus.din = 1'b0;
        bus.fs  = 1'b0;
`ifdef DEMUX_PARITY_EN
        tab = '{'{8'hA5, 1'b1, 8'hA5, 1'b1, 1'b0}, '{8'h3C, 1'b1, 8'h3C, 1'b1, 1'b0},
                '{8'h01, 1'b1, 8'h01, 1'b1, 1'b0}, '{8'h01, 1'b0, 8'h01, 1'b0, 1'b1},
                '{8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0}};
`else
        tab = '{'{8'hA5, 1'b1, 8'hA5, 1'b1, 1'b0}, '{8'h3C, 1'b1, 8'h3C, 1'b1, 1'b0},
                '{8'h01, 1'b1, 8'h01, 1'b1, 1'b0}, '{8'h01, 1'b0, 8'h01, 1'b1, 1'b0},
                '{8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0}};
`endif

        tick(1'b1, 1'b1, 1'b1);
        tick(1'b1, 1'b0, 1'b1);
        check("rst_dout", bus.dout, 8'h00);
        check("rst_locked", bus.locked, 1'b0);
        check("rst_slot", bus.slot, 4'd0);

        foreach (tab[t]) begin
            send_frame(tab[t].data, tab[t].pgood);
            check("tab_dout", bus.dout, tab[t].exp_dout);
            check("tab_valid", bus.dout_valid, tab[t].exp_valid);
            check("tab_perr", bus.par_err, tab[t].exp_perr);
            check("tab_serr", bus.sync_err, 1'b0);
            check("tab_slot", bus.slot, 4'd0);
        end

        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b1);
        check("lock_after_fs", bus.locked, 1'b1);
        check("slot_after_fs", bus.slot, 4'd1);
        for (int k = 1; k < 5; k++) tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b1);
        check("late_fs_serr", bus.sync_err, 1'b1);
        check("late_fs_valid", bus.dout_valid, 1'b0);
        check("late_fs_slot", bus.slot, 4'd1);
        for (int k = 1; k < N; k++) tick(1'b0, k < CH, 1'b0);
        check("restart_dout", bus.dout, 8'hFF);
        check("restart_valid", bus.dout_valid, 1'b1);

        tick(1'b0, 1'b1, 1'b0);
        check("nofs_serr", bus.sync_err, 1'b1);
        check("nofs_locked", bus.locked, 1'b0);
        for (int k = 0; k < 6; k++) tick(1'b0, k[0], 1'b0);
        check("hunt_slot", bus.slot, 4'd0);
        check("hunt_dout", bus.dout, 8'hFF);
        send_frame(8'h5A, 1'b1);
        check("relock_dout", bus.dout, 8'h5A);

        tick(1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        check("midrst_dout", bus.dout, 8'h00);
        check("midrst_slot", bus.slot, 4'd0);
        check("midrst_locked", bus.locked, 1'b0);

        pos = 0;
        repeat (3000) begin
            f = (pos % N) == 0;
            if ($urandom_range(0, 24) == 0) f = !f;
            r = $urandom_range(0, 299) == 0;
            tick(r, 1'($urandom), f);
            pos = (f || r) ? 1 : pos + 1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
